// File: rtl/bsc_pkg.sv
// Shared definitions for the barrel_shift_ctrl block: FSM state encoding,
// operation encoding and the default datapath width.
package bsc_pkg;

  localparam int BSC_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_SHL = 1'b0;
  localparam logic OP_ROL = 1'b1;

endpackage

// File: rtl/shift_step.sv
// One-position left shift (zero fill) or left rotate of a WIDTH-bit word.
// Purely combinational; used as the per-cycle step of the iterative engine.
module shift_step
  import bsc_pkg::*;
#(
  parameter int WIDTH = BSC_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic             op,
  output logic [WIDTH-1:0] result
);

  logic fill;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    fill = 1'b0;
    case (op)
      OP_SHL:  fill = 1'b0;
      OP_ROL:  fill = data[WIDTH-1];
      default: fill = 1'b0;
    endcase
  end

  assign result = {data[WIDTH-2:0], fill};

endmodule

// File: rtl/barrel_shift_ctrl.sv
// Two-requester round-robin front end for a shared left shift/rotate engine.
// Define BSC_SINGLE_CYCLE_EN to compute the full shift at accept (1-cycle latency).
module barrel_shift_ctrl
  import bsc_pkg::*;
#(
  parameter int WIDTH = BSC_WIDTH,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic             req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id,
  output logic             busy
);

  state_t           state;
  state_t           state_nxt;
  logic             last;
  logic             id_q;
  logic [WIDTH-1:0] work;

  logic             gnt_id;
  logic             accept;
  logic [WIDTH-1:0] acc_data;
  logic [AMT_W-1:0] acc_amt;
  logic             acc_op;
  logic [WIDTH-1:0] load_data;

  // Ties go to the requester that was not served last.
  assign gnt_id   = (req0_valid && req1_valid) ? ~last : req1_valid;
  assign acc_data = gnt_id ? req1_data : req0_data;
  assign acc_amt  = gnt_id ? req1_amt  : req0_amt;
  assign acc_op   = gnt_id ? req1_op   : req0_op;
  assign accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);

`ifdef BSC_SINGLE_CYCLE_EN
  logic [WIDTH-1:0] full;

  // Log-stage cascade: stage s applies a fixed shift of 2**s when amt[s] is set.
  always_comb begin
    full = acc_data;
    for (int s = 0; s < AMT_W; s++) begin
      if (acc_amt[s]) begin
        if (acc_op == OP_ROL)
          full = (full << (1 << s)) | (full >> (WIDTH - (1 << s)));
        else
          full = full << (1 << s);
      end
    end
  end

  assign load_data = full;
`else
  logic [AMT_W-1:0] cnt;
  logic             op_q;
  logic [WIDTH-1:0] step_out;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data   (work),
    .op     (op_q),
    .result (step_out)
  );

  assign load_data = acc_data;
`endif

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
`ifdef BSC_SINGLE_CYCLE_EN
          state_nxt = ST_DONE;
`else
          state_nxt = (acc_amt != '0) ? ST_RUN : ST_DONE;
`endif
        end
      end
      ST_RUN: begin
`ifdef BSC_SINGLE_CYCLE_EN
        state_nxt = ST_DONE;
`else
        if (cnt == AMT_W'(1)) state_nxt = ST_DONE;
`endif
      end
      ST_DONE: begin
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != ST_IDLE);
    resp_valid = (state == ST_DONE);
    req0_ready = (state == ST_IDLE) && req0_valid && !gnt_id;
    req1_ready = (state == ST_IDLE) && req1_valid &&  gnt_id;
    resp_data  = work;
    resp_id    = id_q;
  end

  // NOTE: datapath registers are reset too, because resp_data/resp_id are
  // visible outputs with defined reset values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work <= '0;
      id_q <= 1'b0;
      last <= 1'b1;
`ifndef BSC_SINGLE_CYCLE_EN
      cnt  <= '0;
      op_q <= OP_SHL;
`endif
    end else if (accept) begin
      work <= load_data;
      id_q <= gnt_id;
      last <= gnt_id;
`ifndef BSC_SINGLE_CYCLE_EN
      cnt  <= acc_amt;
      op_q <= acc_op;
`endif
    end
`ifndef BSC_SINGLE_CYCLE_EN
    else if (state == ST_RUN) begin
      work <= step_out;
      cnt  <= cnt - AMT_W'(1);
    end
`endif
  end

endmodule

// File: tb/tb_barrel_shift_ctrl.sv
// Self-checking bench for barrel_shift_ctrl: directed table, hand sequences for
// arbitration, back-pressure and mid-operation reset, plus randomized traffic.
module tb_barrel_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic [2:0] req0_amt = '0, req1_amt = '0;
  logic       req0_op = 1'b0, req1_op = 1'b0;
  logic       resp_valid, resp_ready = 1'b0;
  logic [7:0] resp_data;
  logic       resp_id, busy;

  int checks = 0;
  int errors = 0;
  int mlast  = 1;

  barrel_shift_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int data;
    int amt;
    int op;
    int exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: repeated doubling modulo 256, with the carried-out bit
  // re-entering at the bottom for rotate.
  function automatic int ref_op(input int data, input int amt, input int op);
    int v = data;
    for (int i = 0; i < amt; i++)
      v = (op != 0) ? ((v * 2) % 256) + (v / 128) : (v * 2) % 256;
    return v;
  endfunction

  function automatic int exp_lat(input int amt);
`ifdef BSC_SINGLE_CYCLE_EN
    return 1;
`else
    return 1 + amt;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mlast = 1;
  endtask

  // Present up to two requests, confirm the grant, wait for the response,
  // optionally stall the consumer, then consume it.
  task automatic transact(input int v0, input int d0, input int a0, input int o0,
                          input int v1, input int d1, input int a1, input int o1,
                          input int stall);
    int n, lat, gid, egid, ed, ea;
    @(negedge clk);
    req0_valid = v0[0]; req0_data = d0[7:0]; req0_amt = a0[2:0]; req0_op = o0[0];
    req1_valid = v1[0]; req1_data = d1[7:0]; req1_amt = a1[2:0]; req1_op = o1[0];
    #1;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("grant_seen", {31'd0, req0_ready || req1_ready}, 1);
    check("single_grant", {31'd0, req0_ready && req1_ready}, 0);
    egid = (v0 != 0 && v1 != 0) ? 1 - mlast : ((v1 != 0) ? 1 : 0);
    gid  = req1_ready ? 1 : 0;
    check("grant_id", gid, egid);
    mlast = egid;
    ed = (egid == 1) ? ref_op(d1, a1, o1) : ref_op(d0, a0, o0);
    ea = (egid == 1) ? a1 : a0;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk); lat++;
    end
    check("resp_latency", lat, exp_lat(ea));
    check("resp_data", {24'd0, resp_data}, ed);
    check("resp_id", {31'd0, resp_id}, egid);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_hold", {22'd0, resp_valid, resp_id, resp_data}, {22'd0, 1'b1, egid[0], ed[7:0]});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("consumed", {30'd0, resp_valid, busy}, 0);
  endtask

  initial begin : main
    vec_t vecs[7];
    int   grants[$];
    int   ids[$];
    int   bad, n;
    logic [7:0] hold_data;

    vecs[0] = '{0, 'h81, 3, 1, 'h0C};
    vecs[1] = '{1, 'hB5, 2, 0, 'hD4};
    vecs[2] = '{1, 'h5A, 0, 0, 'h5A};
    vecs[3] = '{0, 'hF0, 4, 1, 'h0F};
    vecs[4] = '{1, 'hFF, 7, 0, 'h80};
    vecs[5] = '{0, 'h81, 7, 1, 'hC0};
    vecs[6] = '{1, 'h01, 1, 1, 'h02};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {20'd0, resp_valid, busy, resp_id, req0_ready, req1_ready, resp_data},
          32'd0);
    rst = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("first_tie_req0", {30'd0, req0_ready, req1_ready}, 2'b10);

    // Continuous contention: grants and ids must alternate starting at 0
    req0_data = 8'h01; req0_amt = 3'd1; req0_op = 1'b1;
    req1_data = 8'h01; req1_amt = 3'd1; req1_op = 1'b1;
    resp_ready = 1'b1;
    bad = 0;
    for (int c = 0; c < 24; c++) begin
      if (req0_ready && req1_ready) bad++;
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (resp_valid) begin
        if (resp_data !== 8'h02) bad++;
        ids.push_back(int'(resp_id));
      end
      @(negedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    check("alt_data_ok", bad, 0);
    check("alt_grant_count", {31'd0, grants.size() >= 6}, 1);
    check("alt_resp_count", {31'd0, ids.size() >= 6}, 1);
    bad = 0;
    foreach (grants[i]) if (grants[i] != i % 2) bad++;
    check("alt_grants", bad, 0);
    bad = 0;
    foreach (ids[i]) if (ids[i] != i % 2) bad++;
    check("alt_ids", bad, 0);

    // Directed table, one requester at a time
    do_reset();
    foreach (vecs[i]) begin
      if (ref_op(vecs[i].data, vecs[i].amt, vecs[i].op) != vecs[i].exp_data)
        $display("note: table row %0d disagrees with reference model", i);
      if (vecs[i].id == 0)
        transact(1, vecs[i].data, vecs[i].amt, vecs[i].op, 0, 0, 0, 0, 0);
      else
        transact(0, 0, 0, 0, 1, vecs[i].data, vecs[i].amt, vecs[i].op, 0);
    end

    // Back-pressure: result and readies frozen while resp_ready is low
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'h81; req0_amt = 3'd3; req0_op = 1'b1;
    #1;
    check("bp_accept", {31'd0, req0_ready}, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk); n++;
    end
    check("bp_resp", {24'd0, resp_data}, 32'h0C);
    hold_data = resp_data;
    req1_valid = 1'b1; req1_data = 8'h33; req1_amt = 3'd2; req1_op = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check("bp_hold", {21'd0, resp_valid, resp_id, req0_ready, req1_ready, resp_data},
            {21'd0, 1'b1, 1'b0, 1'b0, 1'b0, hold_data});
    end
    resp_ready = 1'b1;
    #1;
    check("bp_no_accept_on_resp", {30'd0, req0_ready, req1_ready}, 0);
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    check("bp_resume", {30'd0, resp_valid, req1_ready}, 2'b01);
    req1_valid = 1'b0;
    @(negedge clk);
    check("bp_drop_valid_idle", {31'd0, busy}, 0);

    // Reset in the third RUN cycle of an amt=7 operation
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'hFF; req0_amt = 3'd7; req0_op = 1'b0;
    #1;
    check("rst_accept", {31'd0, req0_ready}, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_immediate", {30'd0, resp_valid, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    mlast = 1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (resp_valid || busy) bad++;
    end
    check("rst_no_response", bad, 0);
    transact(1, 'hF0, 4, 1, 0, 0, 0, 0, 0);

    // Randomized traffic against the reference model
    do_reset();
    for (int t = 0; t < 60; t++) begin
      int v0, v1;
      v0 = int'($urandom_range(0, 1));
      v1 = int'($urandom_range(0, 1));
      if (v0 == 0 && v1 == 0) v0 = 1;
      transact(v0, int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 1)),
               v1, int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
